// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: MIPS funct codes,
// FSM state type and small decode helpers.
package alu_pkg;

    localparam int FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic fn_supported(input logic [FUNCT_W-1:0] fn);
        return (fn == FN_AND) || (fn == FN_OR) || (fn == FN_ADD) ||
               (fn == FN_SUB) || (fn == FN_SLT);
    endfunction

    // SUB and SLT both start the ripple with carry-in = 1 (two's complement of b).
    function automatic logic fn_subtracts(input logic [FUNCT_W-1:0] fn);
        return (fn == FN_SUB) || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bus of the bit-serial ALU sequencer.
// master = requester, slave = alu_serial_ctrl.
interface alu_serial_ctrl_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [FUNCT_W-1:0]   signal_in;
    logic [WIDTH-1:0]     operand_a;
    logic [WIDTH-1:0]     operand_b;
    logic                 busy;
    logic                 done;
    logic                 illegal;
    logic [WIDTH-1:0]     result;

    modport master (
        output start, signal_in, operand_a, operand_b,
        input  busy, done, illegal, result
    );

    modport slave (
        input  start, signal_in, operand_a, operand_b,
        output busy, done, illegal, result
    );
endinterface

// File: rtl/alu_serial_shreg.sv
// Loadable right-shift register; shift_in enters at the MSB, bit 0 is
// the bit handed to the slice each cycle.
module alu_serial_shreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        // NOTE: default assignment first so every path assigns q_d; no latch.
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (shift) begin
            q_d = {shift_in, q_q[WIDTH-1:1]};
        end
    end

    // NOTE: non-blocking in clocked logic so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU slice, LSB first.
// Optional `zero` result flag enabled by defining ALU_SERIAL_ZERO_FLAG_EN.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_serial_ctrl_if.slave   bus,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    output logic               zero,
`endif
    output logic               slice_a,
    output logic               slice_b,
    output logic               slice_carry_in,
    output logic [FUNCT_W-1:0] slice_signal,
    output logic               slice_less,
    input  logic               slice_out,
    input  logic               slice_carry_out
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               carry_q,   carry_d;
    logic [FUNCT_W-1:0] op_q,      op_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   result_q,  result_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic               zacc_q,    zacc_d;
    logic               zero_q,    zero_d;
`endif

    logic             sh_load;
    logic             sh_shift;
    logic             last_bit;
    logic             slt_less;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             unused_sh;

    alu_serial_shreg #(.WIDTH(WIDTH)) u_a_sh (
        .clk(clk), .rst(rst), .load(sh_load), .load_val(bus.operand_a),
        .shift(sh_shift), .shift_in(1'b0), .q(a_sh)
    );

    alu_serial_shreg #(.WIDTH(WIDTH)) u_b_sh (
        .clk(clk), .rst(rst), .load(sh_load), .load_val(bus.operand_b),
        .shift(sh_shift), .shift_in(1'b0), .q(b_sh)
    );

    alu_serial_shreg #(.WIDTH(WIDTH)) u_res_sh (
        .clk(clk), .rst(rst), .load(sh_load), .load_val('0),
        .shift(sh_shift), .shift_in(slice_out), .q(res_sh)
    );

    // Only bit 0 of the operand shifters feeds the slice; res_sh[0] is shifted out.
    assign unused_sh = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1], res_sh[0]};

    assign slice_a        = a_sh[0];
    assign slice_b        = b_sh[0];
    assign slice_carry_in = carry_q;
    assign slice_signal   = (op_q == FN_SLT) ? FN_SUB : op_q;
    assign slice_less     = 1'b0;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // Signed less-than: MSB of a-b, flipped when the subtraction overflowed.
    assign slt_less = slice_out ^ (carry_q ^ slice_carry_out);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        op_d      = op_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        result_d  = result_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        zacc_d    = zacc_q;
        zero_d    = zero_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    op_d    = bus.signal_in;
                    cnt_d   = '0;
                    carry_d = fn_subtracts(bus.signal_in);
                    if (fn_supported(bus.signal_in)) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        sh_load = 1'b1;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                        zacc_d  = 1'b0;
`endif
                    end else begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                        result_d  = '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                        zero_d    = 1'b1;
`endif
                    end
                end
            end
            ST_RUN: begin
                busy_d   = 1'b1;
                sh_shift = 1'b1;
                carry_d  = slice_carry_out;
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                zacc_d   = zacc_q | slice_out;
`endif
                if (last_bit) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (op_q == FN_SLT) begin
                        result_d = {{(WIDTH-1){1'b0}}, slt_less};
                    end else begin
                        result_d = {slice_out, res_sh[WIDTH-1:1]};
                    end
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    zero_d = (op_q == FN_SLT) ? ~slt_less : ~(zacc_q | slice_out);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            op_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zacc_q    <= 1'b0;
            zero_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zacc_q    <= zacc_d;
            zero_q    <= zero_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.result  = result_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    assign zero        = zero_q;
`endif

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial sequencer for the team's 1-bit ALU slice. It accepts a WIDTH-bit operation (AND, OR, ADD, SUB, SLT, coded by the 6-bit MIPS funct value) and feeds the slice one bit pair per cycle, LSB first. It collects the slice's result bit and carry-out each cycle and assembles the WIDTH-bit result. It sits directly upstream and downstream of the slice: it drives every slice input and consumes every slice output.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- signal_in  in  6  funct code: AND 6'b100100, OR 6'b100101, ADD 6'b100000, SUB 6'b100010, SLT 6'b101010
- operand_a, operand_b  in  WIDTH  operands, captured on accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, high in DONE
- illegal  out  1  high with done when signal_in was unsupported
- result  out  WIDTH  final result, held until next accepted start
- zero  out  1  result==0 (only with ALU_SERIAL_ZERO_FLAG_EN)
- slice_a, slice_b, slice_carry_in  out  1  slice operand bits / carry
- slice_signal  out  6  function code to slice
- slice_less  out  1  tied 0
- slice_out, slice_carry_out  in  1  slice result bit / carry-out (combinational from slice inputs)

Clock/reset fixed: one clock `clk`; `rst` synchronous, active-high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: capture a_sh=operand_a, b_sh=operand_b, op=signal_in, bit counter cnt=0, carry=1 for SUB/SLT else 0 → RUN. Unsupported op → DONE directly, result=0, illegal=1.
- DONE + start=0 → IDLE.
- RUN each cycle: slice_a=a_sh[0], slice_b=b_sh[0], slice_carry_in=carry, slice_signal=op except SLT drives SUB code (slice zeroes SLT output). Capture carry←slice_carry_out; shift slice_out into res_sh MSB, shift a_sh/b_sh right; cnt++.
- On cnt==WIDTH-1 (last bit), also record cin_msb=carry, cout_msb=slice_carry_out, sum_msb=slice_out → DONE.
- Entering DONE: result=res_sh final value for AND/OR/ADD/SUB. For SLT, result = {WIDTH-1 zeros, sum_msb ^ (cin_msb ^ cout_msb)} (signed less-than, overflow-corrected).
- Arithmetic modulo 2^WIDTH; final carry discarded; no overflow output.
- start during RUN ignored; operands/signal_in changes during RUN ignored.

## Timing
- Reset: state IDLE, busy=0, done=0, illegal=0, result=0, zero=1 (if present), carry=0, shift registers 0.
- Accepted start at edge 0 → busy high cycles 1..WIDTH → done high cycle WIDTH+1. Latency WIDTH+1 cycles; illegal op: done at cycle 1.
- Back-to-back: start in DONE cycle accepted; busy high the next cycle; throughput one op per WIDTH+1 cycles.
- rst during RUN: aborts; next cycle IDLE with reset values; no done.
- rst and start same cycle: rst wins.
- Slice outputs sampled same cycle the inputs are driven (slice purely combinational, within one clock period).

## Configuration
- ALU_SERIAL_ZERO_FLAG_EN defined: `zero` port present; a running-OR flag accumulates slice_out during RUN, and `zero` is updated with `result` on entering DONE (SLT: zero = ~less; illegal: zero=1).
- Undefined: no `zero` port, no accumulator; all other behaviour identical.

## Structure
- Shared package `alu_pkg`: funct constants (FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT), state enum type, funct width constant 6.
- One sub-module: `alu_serial_shreg` — loadable right-shift register, WIDTH parameter, used for a_sh, b_sh and (shift-in at MSB) res_sh.
- The slice itself is external; the bench and top level connect it.

## Test plan
- ADD 5+3, WIDTH=32 → done at cycle 33, result=0x00000008, illegal=0, zero=0.
- SUB 3−5 → result=0xFFFFFFFE; SUB 7−7 → result=0, zero=1 (macro on).
- SLT 0xFFFFFFFF vs 0x00000001 → result=1; SLT 0x7FFFFFFF vs 0xFFFFFFFF (overflow case) → result=0.
- AND 0xF0F0F0F0,0xFF00FF00 → 0xF000F000; OR same → 0xFFF0FFF0; back-to-back start in DONE cycle → second done exactly 33 cycles after first.
- Illegal code 6'b000000 → done at cycle 1, illegal=1, result=0.
- rst asserted at cycle 10 of ADD → next cycle busy=0, done never pulses, result=0; fresh ADD afterward completes correctly.
